// File: rtl/bus_arb2.sv
// bus_arb2: two-master round-robin arbiter in front of a 16x4 synchronous RAM.
// Each transaction walks IDLE -> ACCESS -> WAIT -> ACK -> IDLE, four cycles.

// Per-master grant/ack decode; one instance per master.
module bus_arb2_lane #(
  parameter logic IDX = 1'b0
) (
  input  logic st_busy,
  input  logic st_ack,
  input  logic owner,
  output logic gnt,
  output logic ack
);
  assign gnt = st_busy & (owner == IDX);
  assign ack = st_ack  & (owner == IDX);
endmodule

module bus_arb2 (
  input  logic       clk1000,
  input  logic       clr_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       wen0,
  input  logic       wen1,
  input  logic [3:0] addr0,
  input  logic [3:0] addr1,
  input  logic [3:0] wdata0,
  input  logic [3:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       ack0,
  output logic       ack1,
  output logic [3:0] rdata,
  output logic       ram_wen,
  output logic [3:0] ram_addr,
  output logic [3:0] ram_in,
  input  logic [3:0] ram_out,
  output logic       busy,
  output logic       owner,
  output logic [7:0] txn_cnt,
  output logic [3:0] bus_view
);
  localparam int NUM_M = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  typedef struct packed {
    logic       wen;
    logic [3:0] addr;
    logic [3:0] wdata;
  } mreq_t;

  state_t                state, nxt;
  mreq_t  [NUM_M-1:0]    mreq;
  mreq_t                 lat;
  logic   [NUM_M-1:0]    req_v, gnt_v, ack_v;
  logic                  last_owner, owner_q, win;

  assign req_v = {req1, req0};
  assign mreq  = {{wen1, addr1, wdata1}, {wen0, addr0, wdata0}};

  // Round-robin pick: on a tie the master that did not go last wins;
  // a lone requester always wins.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) win = ~last_owner;
    else              win = req1;
  end

  // Next-state logic; every state except IDLE is exactly one cycle.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (|req_v) nxt = ACCESS;
      ACCESS:  nxt = WAIT;
      WAIT:    nxt = ACK;
      ACK:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register; reset mid-transaction drops straight back to IDLE.
  always_ff @(posedge clk1000 or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= nxt;
  end

  // Request latch, read-data capture, ownership history and transaction count.
  // The latched request keeps the transaction going even if the master
  // drops req or changes its inputs after ACCESS is entered.
  always_ff @(posedge clk1000 or negedge clr_n) begin
    if (!clr_n) begin
      lat        <= '0;
      owner_q    <= 1'b0;
      last_owner <= 1'b1;
      rdata      <= '0;
      txn_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (|req_v) begin
          owner_q <= win;
          lat     <= mreq[win];
        end
        // ram_out is valid here: address was presented in ACCESS.
        WAIT: rdata <= lat.wen ? lat.wdata : ram_out;
        ACK: begin
          txn_cnt    <= txn_cnt + 8'd1;
          last_owner <= owner_q;
        end
        default: ;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_M; g++) begin : g_lane
      bus_arb2_lane #(.IDX(g[0])) u_lane (
        .st_busy (state != IDLE),
        .st_ack  (state == ACK),
        .owner   (owner_q),
        .gnt     (gnt_v[g]),
        .ack     (ack_v[g])
      );
    end
  endgenerate

  assign gnt0     = gnt_v[0];
  assign gnt1     = gnt_v[1];
  assign ack0     = ack_v[0];
  assign ack1     = ack_v[1];
  assign owner    = owner_q;
  assign busy     = (state != IDLE);
  assign ram_wen  = (state == ACCESS) & lat.wen;
  assign ram_addr = lat.addr;
  assign ram_in   = lat.wdata;
  assign bus_view = ((state == ACCESS) && lat.wen) ? lat.wdata : rdata;
endmodule

// File: doc/bus_arb2.md
BUS_ARB2 -- requirements
Module: bus_arb2

Interface
REQ-001 Parameters: none; address and data widths are fixed at 4 bits.
REQ-002 clk1000  in  1  system clock; all state changes on the rising edge.
REQ-003 clr_n  in  1  asynchronous, active-low reset.
REQ-004 req0 / req1  in  1  master 0 / master 1 bus request; held high until that master's ack.
REQ-005 wen0 / wen1  in  1  master write enable: 1 = write, 0 = read; stable while req is high.
REQ-006 addr0 / addr1  in  4  master word address; stable while req is high.
REQ-007 wdata0 / wdata1  in  4  master write data; stable while req is high.
REQ-008 gnt0 / gnt1  out  1  master owns the bus: high in ACCESS, WAIT and ACK.
REQ-009 ack0 / ack1  out  1  one-cycle transaction-complete strobe, high in ACK.
REQ-010 rdata  out  4  read data returned to the owner; valid while ack is high.
REQ-011 ram_wen  out  1  RAM write strobe.
REQ-012 ram_addr  out  4  RAM address.
REQ-013 ram_in  out  4  RAM write data.
REQ-014 ram_out  in  4  RAM read data, valid one cycle after ram_addr is presented (synchronous RAM).
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 owner  out  1  index of the current or most recent owner.
REQ-017 txn_cnt  out  8  count of completed transactions.
REQ-018 bus_view  out  4  display value: ram_in during a write ACCESS, otherwise rdata.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS, WAIT and ACK, each registered.
REQ-020 IDLE: if any req is sampled high, go to ACCESS and latch the winner's wen, addr and wdata into internal registers; otherwise stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: on simultaneous req0 and req1, grant the master that is not last_owner; after reset, last_owner=1, so master 0 wins the first tie.
REQ-022 On a single request, that master SHALL win regardless of last_owner.
REQ-023 ACCESS lasts exactly 1 cycle:
- ram_addr = latched address.
- ram_in = latched data.
- ram_wen = latched wen.
- Next state is WAIT.
REQ-024 ram_wen SHALL be high only in ACCESS and only for writes; a write therefore produces exactly one ram_wen cycle.
REQ-025 ram_addr SHALL hold the latched address in WAIT and ACK; ram_in SHALL hold its last value.
REQ-026 WAIT lasts exactly 1 cycle, then goes to ACK.
REQ-027 For reads, rdata SHALL be loaded from ram_out on the WAIT→ACK edge.
REQ-028 For writes, rdata SHALL be loaded with the written data on the WAIT→ACK edge.
REQ-029 ACK lasts exactly 1 cycle:
- Owner's ack is high.
- txn_cnt increments at the ACK→IDLE edge, wrapping 255→0.
- last_owner updates to the owner.
- Next state is IDLE.
REQ-030 Latency: req sampled in IDLE at edge N → ack high in cycle N+3; minimum spacing between transaction starts is 4 cycles.
REQ-031 Once ACCESS is entered, the transaction SHALL complete even if the owner drops req or changes its inputs.
REQ-032 A requester still high in the IDLE cycle after its ack is treated as a new request.
REQ-033 The non-owner's gnt and ack SHALL remain low throughout another master's transaction.
REQ-034 rdata and bus_view SHALL hold their values between transactions.

Reset
REQ-035 When clr_n=0, the block SHALL asynchronously set:
- State = IDLE, last_owner=1, owner=0.
- gnt0/1, ack0/1 and ram_wen = 0.
- ram_addr, ram_in, rdata, bus_view = 0; txn_cnt=0; busy=0.
REQ-036 Reset asserted mid-transaction SHALL abort it with no further ram_wen and no ack.
REQ-037 The first request SHALL be sampled at the first rising edge after clr_n rises.

Verification
REQ-038 Single write: M0 req with wen=1, addr=1, wdata=1 → ram_wen high for exactly 1 cycle with ram_addr=1 and ram_in=1; ack0 in cycle N+3; txn_cnt=1.
REQ-039 Readback: M0 reads addr=1 after the write → rdata=1 during ack0; bus_view=1; M1 write addr=0, wdata=15 then M1 read addr=0 → rdata=15.
REQ-040 Tie round-robin: req0 and req1 high together after reset → M0 served first, then M1, then M0 again while both are held; gnt and ack are never high for both masters at once.
REQ-041 Abort: clr_n pulled low during WAIT of a write → all outputs 0 immediately; no ack; txn_cnt unchanged at 0.
REQ-042 Early drop: M1 drops req in WAIT → ack1 still pulses in ACK with valid rdata; FSM returns to IDLE.
REQ-043 Wrap: 256 back-to-back transactions → txn_cnt returns to 0; every gap between acks is 4 cycles.
